// File: rtl/fifo_wr_arbiter_ctrl.sv
// fifo_wr_arbiter_ctrl: round-robin write arbiter and pointer/flag controller in front of fifomem
module fifo_wr_arbiter_ctrl #(
    parameter int data  = 14,
    parameter int addr  = 4,
    parameter int AFULL = (1 << addr) - 2
) (
    input  logic            wclk,
    input  logic            wrst,
    input  logic            req0,
    input  logic            req1,
    input  logic [data-1:0] wdata0,
    input  logic [data-1:0] wdata1,
    output logic            gnt0,
    output logic            gnt1,
    input  logic            rd_en,
    output logic [data-1:0] mem_wdata,
    output logic [addr-1:0] waddr,
    output logic [addr-1:0] raddr,
    output logic            wclken,
    output logic            wfull,
    output logic            rempty,
    output logic            afull,
    output logic [addr:0]   count,
    output logic            wdrop,
    output logic            rerr
);
    localparam logic [addr:0] afull_lvl = AFULL[addr:0];

    logic [addr:0] wptr;
    logic [addr:0] rptr;
    logic          last;
    logic          pop;

    assign waddr     = wptr[addr-1:0];
    assign raddr     = rptr[addr-1:0];
    assign wfull     = (wptr[addr] != rptr[addr]) && (wptr[addr-1:0] == rptr[addr-1:0]);
    assign rempty    = wptr == rptr;
    assign count     = wptr - rptr;
    assign afull     = count >= afull_lvl;
    assign wclken    = gnt0 | gnt1;
    assign mem_wdata = gnt1 ? wdata1 : wdata0;
    assign pop       = rd_en && !rempty;

    // grant the lone requester, or on contention the one not served last; nothing when full
    always_comb begin
        gnt0 = !wfull && req0 && (!req1 || last);
        gnt1 = !wfull && req1 && (!req0 || !last);
    end

    // advance pointers on push/pop, remember last winner, flag refused pushes and empty pops
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wptr  <= '0;
            rptr  <= '0;
            last  <= 1'b1;
            wdrop <= 1'b0;
            rerr  <= 1'b0;
        end else begin
            wptr  <= wptr + (addr+1)'(wclken);
            rptr  <= rptr + (addr+1)'(pop);
            last  <= gnt1 ? 1'b1 : gnt0 ? 1'b0 : last;
            wdrop <= wfull && (req0 || req1);
            rerr  <= rd_en && rempty;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter_ctrl.sv
// tb_fifo_wr_arbiter_ctrl: randomized self-checking bench against a queue-based FIFO model
module tb_fifo_wr_arbiter_ctrl;
    logic        wclk = 0;
    logic        wrst = 1;
    logic        req0 = 0, req1 = 0, rd_en = 0;
    logic [13:0] wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, wclken, wfull, rempty, afull, wdrop, rerr;
    logic [13:0] mem_wdata;
    logic [3:0]  waddr, raddr;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter_ctrl dut (
        .wclk(wclk), .wrst(wrst), .req0(req0), .req1(req1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
        .rd_en(rd_en), .mem_wdata(mem_wdata), .waddr(waddr), .raddr(raddr),
        .wclken(wclken), .wfull(wfull), .rempty(rempty), .afull(afull),
        .count(count), .wdrop(wdrop), .rerr(rerr)
    );

    always #5 wclk = ~wclk;

    // stand-in for fifomem
    logic [13:0] mem [16];
    always @(posedge wclk) if (wclken) mem[waddr] <= mem_wdata;

    // reference model: the FIFO as a queue plus who was served last
    logic [13:0] q[$];
    bit          lastw = 1;

    bit          o_g0, o_g1, o_wen, o_drop, o_rerr, e_g0, e_g1, e_drop, e_rerr, popv;
    logic [13:0] o_wd, e_wd, o_head, e_head;
    logic [3:0]  o_waddr, o_raddr;

    task automatic model_reset();
        q.delete();
        lastw = 1;
    endtask

    task automatic cyc(input bit r0, input bit r1, input logic [13:0] d0, input logic [13:0] d1, input bit rd);
        bit full, empty, win1;
        @(negedge wclk);
        req0 = r0; req1 = r1; wdata0 = d0; wdata1 = d1; rd_en = rd;
        #1;
        o_g0 = gnt0; o_g1 = gnt1; o_wen = wclken; o_wd = mem_wdata;
        o_head = mem[raddr]; o_raddr = raddr; o_waddr = waddr;
        full  = q.size() == 16;
        empty = q.size() == 0;
        win1  = (r0 && r1) ? !lastw : r1;
        e_g0  = !full && (r0 || r1) && !win1;
        e_g1  = !full && (r0 || r1) && win1;
        e_wd  = e_g1 ? d1 : d0;
        e_head = empty ? 14'h0 : q[0];
        popv  = rd && !empty;
        e_drop = full && (r0 || r1);
        e_rerr = rd && empty;
        @(posedge wclk);
        if (popv) void'(q.pop_front());
        if (e_g0 || e_g1) begin
            q.push_back(e_wd);
            lastw = e_g1;
        end
        #1;
        o_drop = wdrop; o_rerr = rerr;
    endtask

    task automatic do_reset();
        @(negedge wclk);
        req0 = 0; req1 = 0; rd_en = 0;
        wrst = 1;
        model_reset();
        @(negedge wclk);
        wrst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 0, 14'(i + 100), 0, 0);
        checks++;
        if (count !== 5'd5) begin errors++; $display("FAIL reset_pre count got %0d exp 5", count); end
        #2;
        req0 = 0; wrst = 1;
        model_reset();
        #1;
        checks++;
        if (count !== 0 || rempty !== 1 || wfull !== 0 || gnt0 !== 0 || gnt1 !== 0 || afull !== 0 || wclken !== 0)
        begin errors++; $display("FAIL reset_async cnt=%0d emp=%b full=%b g=%b%b got, exp 0 1 0 00", count, rempty, wfull, gnt0, gnt1); end
        @(negedge wclk);
        wrst = 0;
        cyc(1, 0, 14'h1234, 0, 0);
        checks++;
        if (o_g0 !== 1 || o_waddr !== 0) begin errors++; $display("FAIL reset_first_write g0=%b waddr=%0d exp 1 0", o_g0, o_waddr); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 14'(i), 14'h3fff, 0);
            checks++;
            if (o_g0 !== 1 || o_g1 !== 0 || o_wd !== 14'(i)) begin errors++; $display("FAIL fill_gnt i=%0d g=%b%b wd=%h exp 10 %h", i, o_g0, o_g1, o_wd, i); end
            checks++;
            if (count !== 5'(i + 1) || afull !== (i + 1 >= 14) || wfull !== (i == 15))
            begin errors++; $display("FAIL fill_flags i=%0d cnt=%0d af=%b f=%b exp %0d %b %b", i, count, afull, wfull, i + 1, i + 1 >= 14, i == 15); end
        end
        cyc(1, 0, 14'h2aaa, 0, 0);
        checks++;
        if (o_g0 !== 0 || o_wen !== 0 || o_drop !== 1 || count !== 5'd16 || mem[0] !== 0)
        begin errors++; $display("FAIL fill_17th g0=%b wen=%b drop=%b cnt=%0d m0=%h exp 0 0 1 16 0", o_g0, o_wen, o_drop, count, mem[0]); end
        cyc(0, 0, 0, 0, 0);
        checks++;
        if (o_drop !== 0) begin errors++; $display("FAIL fill_drop_pulse wdrop=%b exp 0", o_drop); end
    endtask

    task automatic test_round_robin();
        logic [13:0] a, b;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            a = 14'($urandom); b = 14'($urandom);
            cyc(1, 1, a, b, 0);
            checks++;
            if (o_g0 !== (i % 2 == 0) || o_g1 !== (i % 2 == 1) || o_wd !== ((i % 2 == 1) ? b : a))
            begin errors++; $display("FAIL rr i=%0d g=%b%b wd=%h exp g1=%0d", i, o_g0, o_g1, o_wd, i % 2); end
        end
        checks++;
        if (count !== 5'd6) begin errors++; $display("FAIL rr_count got %0d exp 6", count); end
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 14'($urandom), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1);
            checks++;
            if (o_raddr !== 4'(i) || o_head !== e_head || o_rerr !== 0)
            begin errors++; $display("FAIL drain i=%0d raddr=%0d head=%h rerr=%b exp %0d %h 0", i, o_raddr, o_head, o_rerr, i, e_head); end
        end
        checks++;
        if (rempty !== 1) begin errors++; $display("FAIL drain_empty rempty=%b exp 1", rempty); end
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (o_rerr !== 1 || raddr !== 4'd3 || count !== 0) begin errors++; $display("FAIL underflow rerr=%b raddr=%0d cnt=%0d exp 1 3 0", o_rerr, raddr, count); end
        cyc(0, 0, 0, 0, 0);
        checks++;
        if (o_rerr !== 0) begin errors++; $display("FAIL rerr_pulse rerr=%b exp 0", o_rerr); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 0, 14'($urandom), 0, 0);
        cyc(1, 0, 14'h0155, 0, 1);
        checks++;
        if (count !== 5'd8 || o_g0 !== 1 || o_head !== e_head) begin errors++; $display("FAIL simul_mid cnt=%0d g0=%b exp 8 1", count, o_g0); end
        while (q.size() < 16) cyc(1, 0, 14'($urandom), 0, 0);
        cyc(1, 0, 14'h0aaa, 0, 1);
        checks++;
        if (count !== 5'd15 || o_g0 !== 0 || o_drop !== 1 || o_head !== e_head)
        begin errors++; $display("FAIL simul_full cnt=%0d g0=%b drop=%b exp 15 0 1", count, o_g0, o_drop); end
        while (q.size() > 0) cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 0, 14'h0777, 1);
        checks++;
        if (count !== 5'd1 || o_g1 !== 1 || o_rerr !== 1) begin errors++; $display("FAIL simul_empty cnt=%0d g1=%b rerr=%b exp 1 1 1", count, o_g1, o_rerr); end
    endtask

    task automatic test_wrap();
        bit r1;
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, 14'($urandom), 0, 0);
        for (int i = 0; i < 40; i++) begin
            r1 = 1'($urandom);
            cyc(!r1, r1, 14'($urandom), 14'($urandom), 1);
            checks++;
            if (o_head !== e_head || count !== 5'd3 || wfull !== 0 || (o_g0 | o_g1) !== 1)
            begin errors++; $display("FAIL wrap i=%0d head=%h cnt=%0d full=%b exp %h 3 0", i, o_head, count, wfull, e_head); end
        end
    endtask

    task automatic test_random();
        bit r0, r1, rd;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 1) != 0);
            rd = ($urandom_range(0, 2) == 0) || (i > 300 && ($urandom_range(0, 1) != 0));
            cyc(r0, r1, 14'($urandom), 14'($urandom), rd);
            checks++;
            if (o_g0 !== e_g0 || o_g1 !== e_g1 || o_wen !== (e_g0 | e_g1) || ((e_g0 | e_g1) && o_wd !== e_wd))
            begin errors++; $display("FAIL rand_gnt i=%0d g=%b%b wd=%h exp %b%b %h", i, o_g0, o_g1, o_wd, e_g0, e_g1, e_wd); end
            checks++;
            if ((popv && o_head !== e_head) || o_drop !== e_drop || o_rerr !== e_rerr || count !== 5'(q.size()) ||
                rempty !== (q.size() == 0) || wfull !== (q.size() == 16) || afull !== (q.size() >= 14))
            begin errors++; $display("FAIL rand_state i=%0d cnt=%0d drop=%b rerr=%b head=%h exp %0d %b %b %h", i, count, o_drop, o_rerr, o_head, q.size(), e_drop, e_rerr, e_head); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_round_robin();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter_ctrl.md
# fifo_wr_arbiter_ctrl

Single-clock controller that sequences the shared `fifomem` storage array. It arbitrates two write requesters round-robin onto the single memory write port and generates the memory write/read addresses, the write enable and the full gate. It also maintains occupancy, full/empty/almost-full flags and drop/underflow indications. It sits directly in front of `fifomem`, whose combinational `rdata` presents the head entry (first-word-fall-through).

## Interface
- `data`, 14: data word width (matches `fifomem`).
- `addr`, 4: memory address bits; DEPTH = 1<<addr.
- `AFULL`, DEPTH-2: almost-full threshold on occupancy.
---
- `wclk`  in  1  single clock; all state on rising edge.
- `wrst`  in  1  reset; asynchronous, active-high.
- `req0`, `req1`  in  1  write request, requester 0/1.
- `wdata0`, `wdata1`  in  data  write data, requester 0/1.
- `gnt0`, `gnt1`  out  1  combinational grant; the word is written at this edge.
- `rd_en`  in  1  pop request from consumer.
- `mem_wdata`  out  data  muxed write data to `fifomem.wdata`.
- `waddr`, `raddr`  out  addr  to `fifomem`.
- `wclken`  out  1  to `fifomem.wclken`; equals gnt0|gnt1.
- `wfull`  out  1  full flag; also drives `fifomem.wfull`.
- `rempty`  out  1  empty flag; head data invalid when high.
- `afull`  out  1  count >= AFULL.
- `count`  out  addr+1  occupancy, 0..DEPTH.
- `wdrop`  out  1  registered pulse: a request was refused because full.
- `rerr`  out  1  registered pulse: rd_en while empty.

## Operation
- State: `wptr`, `rptr` (addr+1 bits each, binary), `last` (last granted requester), and the `wdrop`/`rerr` registers.
- `waddr` = wptr[addr-1:0]; `raddr` = rptr[addr-1:0].
- `wfull` = (wptr[addr] != rptr[addr]) && (low bits equal). `rempty` = (wptr == rptr). `count` = wptr - rptr, modulo 2^(addr+1). All are decoded from registered state, with no input paths.
- Arbitration happens only when !wfull:
  - A single request is granted.
  - When both request, the requester not equal to `last` wins.
  - `last` updates on every grant.
  - Never more than one grant per cycle.
- When wfull, both grants are 0 and `wdrop` is set next cycle if any request was present. The requester must hold its request, because nothing is queued.
- `mem_wdata` = gnt1 ? wdata1 : wdata0.
- Push: on a grant, wptr increments at the edge.
- Pop: rd_en && !rempty increments rptr. rd_en while empty sets `rerr` next cycle; rptr is unchanged.
- Simultaneous push and pop:
  - Neither empty nor full: both pointers advance and count is unchanged.
  - Full: the pop proceeds and the push is refused (wfull is evaluated pre-edge); `wdrop` pulses.
  - Empty: the push proceeds and the pop is ignored with `rerr` pulsing (no bypass).
- Wrap-around: pointers roll over naturally from 2^(addr+1)-1 to 0; the MSB toggles each lap.

## Timing
- Reset (async assert, removal synchronous to wclk):
  - wptr = rptr = 0, last = 1 (requester 0 wins first contention).
  - wdrop = rerr = 0.
  - Hence rempty = 1, wfull = 0, afull = 0, count = 0, waddr = raddr = 0, gnt = 0, wclken = 0.
- Reset asserted mid-operation clears all state immediately. Stored memory contents are not cleared but are unreachable.
- Grant is 0-latency: combinational from req and registered state. Data is stored at the same edge.
- Written data is visible at the head (`fifomem.rdata`) the cycle after the push edge. rempty deasserts in that same cycle.
- Flags and count update one edge after the causing push/pop.
- wdrop and rerr are 1-cycle pulses, one edge late.

## Test plan
- Reset/idle: assert wrst mid-traffic with count = 5 -> immediately count = 0, rempty = 1, wfull = 0, gnts = 0. After release, a req0 write lands at waddr 0.
- Fill/full: req0 alone for 16 cycles with data 0..15 -> gnt0 each cycle, count reaches 16, wfull = 1, afull = 1 from count 14. A 17th request gives gnt0 = 0, wdrop pulse, no memory write.
- Round-robin: req0 = req1 = 1 held for 6 cycles from reset -> grants 0,1,0,1,0,1; mem_wdata follows the granted source; count = 6.
- Drain/underflow: from 3 entries, rd_en for 4 cycles -> raddr 0,1,2 with matching data, rempty after the 3rd pop; the 4th pop gives a rerr pulse and rptr is unchanged.
- Simultaneous ops:
  - At count = 8, push and pop together -> count stays 8.
  - At full, push and pop -> count 15 with a wdrop pulse.
  - At empty, push and pop -> count 1 with a rerr pulse.
- Wrap: 40 push/pop pairs at steady count = 3 -> data order preserved across two pointer laps; wfull never asserts.
